// File: rtl/memory_arbiter_pkg.sv
// Shared types for the memory arbiter: the machine word type and the
// arbiter state encoding.
package memory_arbiter_pkg;

  localparam int REGVAL_W = 32;

  typedef logic [REGVAL_W-1:0] regval_t;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FETCH      = 2'd1,
    DATA_READ  = 2'd2,
    DATA_WRITE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// Requester and memory-side signals of the arbiter, bundled as one interface.
// The arbiter connects through the slave modport; its environment uses master.
interface memory_arbiter_if;
  import memory_arbiter_pkg::*;

  logic    fetch_req;
  regval_t fetch_address;
  logic    fetch_valid;
  regval_t fetch_data;
  logic    flush;

  logic    data_req;
  logic    data_is_reading;
  logic    data_is_writing;
  regval_t data_address;
  regval_t data_write_value;
  logic    data_done;
  regval_t data_read_value;

  regval_t mem_address;
  logic    mem_read;
  logic    mem_write;
  regval_t mem_write_data;
  regval_t mem_read_data;
  logic    mem_wait;

  modport slave (
    input  fetch_req, fetch_address, flush,
    input  data_req, data_is_reading, data_is_writing, data_address, data_write_value,
    input  mem_read_data, mem_wait,
    output fetch_valid, fetch_data, data_done, data_read_value,
    output mem_address, mem_read, mem_write, mem_write_data
  );

  modport master (
    output fetch_req, fetch_address, flush,
    output data_req, data_is_reading, data_is_writing, data_address, data_write_value,
    output mem_read_data, mem_wait,
    input  fetch_valid, fetch_data, data_done, data_read_value,
    input  mem_address, mem_read, mem_write, mem_write_data
  );

endinterface

// File: rtl/memory_arbiter.sv
// Shares one memory port between instruction fetch and data accesses, with
// starvation protection for fetch and an atomic read-then-write exchange (cx).
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clock,
  input  logic            reset_n,
  memory_arbiter_if.slave bus
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_t       state_q, state_d;
  regval_t          mem_address_q, mem_address_d;
  logic             mem_read_q, mem_read_d;
  logic             mem_write_q, mem_write_d;
  regval_t          write_data_q, write_data_d;
  logic             exchange_q, exchange_d;
  logic             flushed_q, flushed_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             fetch_valid_q, fetch_valid_d;
  regval_t          fetch_data_q, fetch_data_d;
  logic             data_done_q, data_done_d;
  regval_t          read_value_q, read_value_d;
  logic             fetch_wins;
  logic             fetch_killed;

  always_comb begin
    state_d       = state_q;
    mem_address_d = mem_address_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    write_data_d  = write_data_q;
    exchange_d    = exchange_q;
    flushed_d     = flushed_q;
    starve_d      = starve_q;
    fetch_data_d  = fetch_data_q;
    read_value_d  = read_value_q;
    fetch_valid_d = 1'b0;
    data_done_d   = 1'b0;
    fetch_wins    = bus.fetch_req && (!bus.data_req || starve_q == STARVE_MAX);
    fetch_killed  = flushed_q || bus.flush;

    unique case (state_q)
      IDLE: begin
        if (!bus.fetch_req) starve_d = '0;
        if (fetch_wins) begin
          state_d       = FETCH;
          mem_read_d    = 1'b1;
          mem_address_d = bus.fetch_address;
          flushed_d     = bus.flush;
          starve_d      = '0;
        end else if (bus.data_req) begin
          if (bus.fetch_req && starve_q != STARVE_MAX) starve_d = starve_q + CNT_W'(1);
          mem_address_d = bus.data_address;
          write_data_d  = bus.data_write_value;
          exchange_d    = bus.data_is_reading && bus.data_is_writing;
          if (bus.data_is_reading) begin
            state_d    = DATA_READ;
            mem_read_d = 1'b1;
          end else if (bus.data_is_writing) begin
            state_d     = DATA_WRITE;
            mem_write_d = 1'b1;
          end else begin
            data_done_d = 1'b1;
          end
        end
      end

      // A flushed fetch still finishes its bus read; only the result is dropped.
      FETCH: begin
        flushed_d = fetch_killed;
        if (!bus.mem_wait) begin
          state_d    = IDLE;
          mem_read_d = 1'b0;
          flushed_d  = 1'b0;
          if (!fetch_killed) begin
            fetch_data_d  = bus.mem_read_data;
            fetch_valid_d = 1'b1;
          end
        end
      end

      DATA_READ: begin
        if (!bus.mem_wait) begin
          read_value_d = bus.mem_read_data;
          mem_read_d   = 1'b0;
          if (exchange_q) begin
            state_d     = DATA_WRITE;
            mem_write_d = 1'b1;
          end else begin
            state_d     = IDLE;
            data_done_d = 1'b1;
          end
        end
      end

      DATA_WRITE: begin
        if (!bus.mem_wait) begin
          state_d     = IDLE;
          mem_write_d = 1'b0;
          data_done_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      mem_address_q <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      write_data_q  <= '0;
      exchange_q    <= 1'b0;
      flushed_q     <= 1'b0;
      starve_q      <= '0;
      fetch_valid_q <= 1'b0;
      fetch_data_q  <= '0;
      data_done_q   <= 1'b0;
      read_value_q  <= '0;
    end else begin
      state_q       <= state_d;
      mem_address_q <= mem_address_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      write_data_q  <= write_data_d;
      exchange_q    <= exchange_d;
      flushed_q     <= flushed_d;
      starve_q      <= starve_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_data_q  <= fetch_data_d;
      data_done_q   <= data_done_d;
      read_value_q  <= read_value_d;
    end
  end

  assign bus.mem_address     = mem_address_q;
  assign bus.mem_read        = mem_read_q;
  assign bus.mem_write       = mem_write_q;
  assign bus.mem_write_data  = write_data_q;
  assign bus.fetch_valid     = fetch_valid_q;
  assign bus.fetch_data      = fetch_data_q;
  assign bus.data_done       = data_done_q;
  assign bus.data_read_value = read_value_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios followed by
// randomized fetch/data traffic against a word-level memory reference model.
module tb_memory_arbiter;

  localparam int STARVE_LIMIT = 4;

  logic clock;
  logic reset_n;

  memory_arbiter_if bus();

  memory_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory device: unwritten words read back a fixed address-derived pattern.
  logic [31:0] mem_array [0:255];
  bit          mem_valid [0:255];
  int          wait_cycles = 0;
  bit          rand_wait   = 1'b0;
  int          rand_cycles = 0;
  int          wait_cnt    = 0;
  int          cur_wait;

  typedef struct {
    bit          is_write;
    logic [31:0] addr;
    logic [31:0] data;
  } bus_evt_t;
  bus_evt_t bus_log[$];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  always_comb begin
    cur_wait          = rand_wait ? rand_cycles : wait_cycles;
    bus.mem_wait      = (bus.mem_read || bus.mem_write) && (wait_cnt < cur_wait);
    bus.mem_read_data = 32'h0;
    if (bus.mem_read)
      bus.mem_read_data = mem_valid[bus.mem_address[9:2]] ? mem_array[bus.mem_address[9:2]]
                                                          : init_word(bus.mem_address);
  end

  always @(posedge clock) begin
    if (bus.mem_read || bus.mem_write) begin
      if (bus.mem_wait) begin
        wait_cnt <= wait_cnt + 1;
      end else begin
        wait_cnt <= 0;
        if (bus.mem_write) begin
          mem_array[bus.mem_address[9:2]] <= bus.mem_write_data;
          mem_valid[bus.mem_address[9:2]] <= 1'b1;
        end
        bus_log.push_back('{bus.mem_write, bus.mem_address,
                            bus.mem_write ? bus.mem_write_data : bus.mem_read_data});
        rand_cycles <= $urandom_range(0, 2);
      end
    end else begin
      wait_cnt <= 0;
    end
  end

  // Reference model: expected memory contents after each completed data access.
  logic [31:0] model_mem [logic [31:0]];

  function automatic logic [31:0] model_read(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] dev_read(input logic [31:0] a);
    return mem_valid[a[9:2]] ? mem_array[a[9:2]] : init_word(a);
  endfunction

  function automatic logic [32:0] log_entry(input int i);
    if (i < bus_log.size()) return {bus_log[i].is_write, bus_log[i].addr};
    return 'x;
  endfunction

  function automatic logic [31:0] log_data(input int i);
    if (i < bus_log.size()) return bus_log[i].data;
    return 'x;
  endfunction

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected)
      else begin
        n_fail++;
        $error("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, observed, expected);
      end
  endtask

  // Runs one data access, optionally alongside one fetch, until both finish.
  task automatic run_pair(input bit use_fetch, input logic [31:0] f_addr,
                          input bit rd, input bit wr, input logic [31:0] d_addr,
                          input logic [31:0] wdata,
                          output int done_at, output int valid_at,
                          output logic [31:0] rval, output logic [31:0] fdata);
    done_at  = -1;
    valid_at = -1;
    rval     = '0;
    fdata    = '0;
    bus.data_req         = 1'b1;
    bus.data_is_reading  = rd;
    bus.data_is_writing  = wr;
    bus.data_address     = d_addr;
    bus.data_write_value = wdata;
    if (use_fetch) begin
      bus.fetch_req     = 1'b1;
      bus.fetch_address = f_addr;
    end
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      if (bus.data_done && done_at < 0) begin
        done_at      = c;
        rval         = bus.data_read_value;
        bus.data_req = 1'b0;
        if (wr) model_mem[d_addr] = wdata;
      end
      if (bus.fetch_valid && valid_at < 0) begin
        valid_at      = c;
        fdata         = bus.fetch_data;
        bus.fetch_req = 1'b0;
      end
      if (done_at >= 0 && (valid_at >= 0 || !use_fetch)) break;
    end
    bus.data_req  = 1'b0;
    bus.fetch_req = 1'b0;
  endtask

  int          base;
  int          done_at, valid_at;
  logic [31:0] rval, fdata;
  int          pulses;
  int          n_st;
  bit          fetch_seen;
  int          first_read;
  bit          f_pend, d_pend, r_rd, r_wr;
  logic [31:0] r_faddr, r_daddr, r_wdata;
  int          dones_since;
  int          kind;

  initial begin
    reset_n              = 1'b0;
    bus.fetch_req        = 1'b0;
    bus.fetch_address    = '0;
    bus.flush            = 1'b0;
    bus.data_req         = 1'b0;
    bus.data_is_reading  = 1'b0;
    bus.data_is_writing  = 1'b0;
    bus.data_address     = '0;
    bus.data_write_value = '0;

    $display("[TB] reset state");
    repeat (2) @(negedge clock);
    check("rst_mem_read", bus.mem_read, 1'b0);
    check("rst_mem_write", bus.mem_write, 1'b0);
    check("rst_fetch_valid", bus.fetch_valid, 1'b0);
    check("rst_data_done", bus.data_done, 1'b0);
    check("rst_mem_address", bus.mem_address, 32'h0);
    check("rst_mem_write_data", bus.mem_write_data, 32'h0);
    check("rst_fetch_data", bus.fetch_data, 32'h0);
    check("rst_data_read_value", bus.data_read_value, 32'h0);
    reset_n = 1'b1;
    @(negedge clock);

    $display("[TB] single fetch at 0x100");
    bus.fetch_req     = 1'b1;
    bus.fetch_address = 32'h100;
    @(negedge clock);
    check("fetch_strobe", bus.mem_read, 1'b1);
    check("fetch_addr", bus.mem_address, 32'h100);
    check("fetch_no_write", bus.mem_write, 1'b0);
    check("fetch_valid_early", bus.fetch_valid, 1'b0);
    @(negedge clock);
    check("fetch_valid_lat2", bus.fetch_valid, 1'b1);
    check("fetch_data", bus.fetch_data, init_word(32'h100));
    bus.fetch_req = 1'b0;
    @(negedge clock);
    check("fetch_valid_pulse", bus.fetch_valid, 1'b0);
    check("fetch_strobe_drop", bus.mem_read, 1'b0);

    $display("[TB] data beats fetch");
    base = bus_log.size();
    run_pair(1'b1, 32'h104, 1'b1, 1'b0, 32'h200, 32'h0, done_at, valid_at, rval, fdata);
    check("pri_done_lat2", done_at, 2);
    check("pri_done_first", (valid_at > done_at), 1'b1);
    check("pri_ld_value", rval, model_read(32'h200));
    check("pri_fetch_data", fdata, init_word(32'h104));
    check("pri_bus0", log_entry(base), {1'b0, 32'h200});
    check("pri_bus1", log_entry(base + 1), {1'b0, 32'h104});

    $display("[TB] atomic exchange at 0x300");
    run_pair(1'b0, 32'h0, 1'b0, 1'b1, 32'h300, 32'hAA, done_at, valid_at, rval, fdata);
    check("preload_done", (done_at > 0), 1'b1);
    wait_cycles = 2;
    @(negedge clock);
    base = bus_log.size();
    run_pair(1'b1, 32'h108, 1'b1, 1'b1, 32'h300, 32'h55, done_at, valid_at, rval, fdata);
    check("cx_done_seen", (done_at > 0), 1'b1);
    check("cx_old_value", rval, 32'hAA);
    check("cx_fetch_after", (valid_at > done_at), 1'b1);
    check("cx_bus_read", log_entry(base), {1'b0, 32'h300});
    check("cx_bus_write", log_entry(base + 1), {1'b1, 32'h300});
    check("cx_bus_wdata", log_data(base + 1), 32'h55);
    check("cx_bus_fetch", log_entry(base + 2), {1'b0, 32'h108});
    check("cx_mem_value", dev_read(32'h300), 32'h55);

    $display("[TB] flushed fetch");
    wait_cycles       = 3;
    base              = bus_log.size();
    bus.fetch_req     = 1'b1;
    bus.fetch_address = 32'h10C;
    @(negedge clock);
    check("flush_granted", bus.mem_read, 1'b1);
    bus.flush     = 1'b1;
    bus.fetch_req = 1'b0;
    @(negedge clock);
    bus.flush = 1'b0;
    pulses    = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (bus.fetch_valid) pulses++;
    end
    check("flush_no_valid", pulses, 0);
    check("flush_bus_done", log_entry(base), {1'b0, 32'h10C});
    check("flush_strobe_drop", bus.mem_read, 1'b0);

    $display("[TB] fetch starvation limit");
    wait_cycles          = 0;
    base                 = bus_log.size();
    n_st                 = 0;
    fetch_seen           = 1'b0;
    bus.fetch_req        = 1'b1;
    bus.fetch_address    = 32'h110;
    bus.data_req         = 1'b1;
    bus.data_is_reading  = 1'b0;
    bus.data_is_writing  = 1'b1;
    bus.data_address     = 32'h240;
    bus.data_write_value = 32'h5000;
    for (int c = 0; c < 80; c++) begin
      @(negedge clock);
      if (bus.fetch_valid) begin
        fetch_seen    = 1'b1;
        fdata         = bus.fetch_data;
        bus.fetch_req = 1'b0;
      end
      if (bus.data_done) begin
        model_mem[bus.data_address] = bus.data_write_value;
        n_st++;
        if (fetch_seen) begin
          bus.data_req = 1'b0;
          break;
        end
        bus.data_address     = 32'h240 + 32'(4 * n_st);
        bus.data_write_value = 32'h5000 + 32'(n_st);
      end
    end
    bus.data_req  = 1'b0;
    bus.fetch_req = 1'b0;
    first_read = -1;
    for (int i = base; i < bus_log.size(); i++)
      if (!bus_log[i].is_write && first_read < 0) first_read = i - base;
    check("starve_fetch_seen", fetch_seen, 1'b1);
    check("starve_fifth_grant", first_read, STARVE_LIMIT);
    check("starve_fetch_addr", log_entry(base + STARVE_LIMIT), {1'b0, 32'h110});
    check("starve_fetch_data", fdata, init_word(32'h110));
    @(negedge clock);

    $display("[TB] reset during write");
    wait_cycles          = 10;
    bus.data_req         = 1'b1;
    bus.data_is_reading  = 1'b0;
    bus.data_is_writing  = 1'b1;
    bus.data_address     = 32'h2F0;
    bus.data_write_value = 32'h1234;
    @(negedge clock);
    check("rstw_strobe", bus.mem_write, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("rstw_write_drop", bus.mem_write, 1'b0);
    check("rstw_read_drop", bus.mem_read, 1'b0);
    @(negedge clock);
    bus.data_req = 1'b0;
    reset_n      = 1'b1;
    pulses       = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (bus.data_done || bus.mem_write) pulses++;
    end
    check("rstw_no_done", pulses, 0);
    check("rstw_mem_untouched", dev_read(32'h2F0), model_read(32'h2F0));

    $display("[TB] randomized traffic");
    rand_wait   = 1'b1;
    f_pend      = 1'b0;
    d_pend      = 1'b0;
    r_rd        = 1'b0;
    r_wr        = 1'b0;
    r_faddr     = '0;
    r_daddr     = '0;
    r_wdata     = '0;
    dones_since = 0;
    for (int c = 0; c < 1800; c++) begin
      @(negedge clock);
      if (bus.fetch_valid) begin
        check("rnd_fetch_expected", f_pend, 1'b1);
        check("rnd_fetch_data", bus.fetch_data, init_word(r_faddr));
        check("rnd_starve_bound", (dones_since <= STARVE_LIMIT + 1), 1'b1);
        f_pend        = 1'b0;
        bus.fetch_req = 1'b0;
      end
      if (bus.data_done) begin
        check("rnd_done_expected", d_pend, 1'b1);
        if (r_rd) check("rnd_read_value", bus.data_read_value, model_read(r_daddr));
        if (r_wr) model_mem[r_daddr] = r_wdata;
        d_pend       = 1'b0;
        bus.data_req = 1'b0;
        if (f_pend) dones_since++;
      end
      if (c >= 1500 && !f_pend && !d_pend) break;
      if (c < 1500 && !f_pend && $urandom_range(0, 3) == 0) begin
        r_faddr           = 32'h100 + 32'(4 * $urandom_range(0, 63));
        f_pend            = 1'b1;
        dones_since       = 0;
        bus.fetch_address = r_faddr;
        bus.fetch_req     = 1'b1;
      end
      if (c < 1500 && !d_pend && $urandom_range(0, 2) == 0) begin
        kind                 = $urandom_range(0, 3);
        r_rd                 = (kind == 1) || (kind == 3);
        r_wr                 = (kind >= 2);
        r_daddr              = 32'h200 + 32'(4 * $urandom_range(0, 63));
        r_wdata              = $urandom;
        d_pend               = 1'b1;
        bus.data_is_reading  = r_rd;
        bus.data_is_writing  = r_wr;
        bus.data_address     = r_daddr;
        bus.data_write_value = r_wdata;
        bus.data_req         = 1'b1;
      end
    end
    check("rnd_fetch_drained", f_pend, 1'b0);
    check("rnd_data_drained", d_pend, 1'b0);
    for (int i = 0; i <= 64; i++)
      check("rnd_mem_image", dev_read(32'h200 + 32'(4 * i)), model_read(32'h200 + 32'(4 * i)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, observed no finish required finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
